seq_mag_comparator: RTL and testbench
=====================================

Name: seq_mag_comparator

Overview:
- Parametrised multi-cycle magnitude comparator; successor to the team's 2-bit combinational comparator.
- Compares two WIDTH-bit operands CHUNK bits per cycle, MSB chunk first.
- Supports a per-transaction signed/unsigned mode and valid/ready handshakes on input and output.
- Returns the same one-hot {gt, eq, lt} 3-bit result encoding the team already uses.

Parameters:
- WIDTH, 16, operand width in bits; must be >= 2.
- CHUNK, 4, bits compared per cycle; must be >= 1 and divide WIDTH; NCHUNK = WIDTH/CHUNK.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands and mode valid.
- in_ready  output  1  block can accept a transaction.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- signed_mode  input  1  1 = two's-complement compare; 0 = unsigned.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out  output  3  out[2] = A>B, out[1] = A==B, out[0] = A<B; exactly one bit set when out_valid.
- busy  output  1  high in COMPARE or DONE.

Behaviour:
- Reset (async, immediate):
  - state = IDLE, out = 3'b000, out_valid = 0, in_ready = 1, busy = 0.
  - Captured operands, chunk index and decided flag are cleared.
- IDLE:
  - in_ready = 1.
  - On a rising edge with in_valid = 1, capture a, b and signed_mode, set idx = NCHUNK-1, clear decided/result, go to COMPARE.
- COMPARE:
  - in_ready = 0. Each cycle compares chunk idx (bits idx*CHUNK+CHUNK-1 .. idx*CHUNK) as unsigned.
  - For the top chunk, when the captured signed_mode = 1, the MSB of both chunks is inverted before comparing.
  - If not yet decided and chunks differ: latch gt or lt and set decided.
  - When idx = 0 and this is the final compare: result = decided ? latched : eq. Load out, go to DONE. Otherwise decrement idx.
  - Latency without the optional feature: out_valid rises exactly NCHUNK cycles after the accepting edge, independent of the data.
  - When CHUNK = WIDTH, latency is 1 cycle.
- DONE:
  - out_valid = 1; out is stable.
  - On a rising edge with out_ready = 1, go to IDLE and clear out_valid. in_ready returns to 1 in the following cycle; there is no same-cycle accept.
  - in_valid is ignored while busy.
- out holds its last result after the handshake until the next DONE entry or reset. out is meaningful only when out_valid = 1.
- Operand and mode inputs may change freely after acceptance; only captured copies are used.
- Reset mid-COMPARE or mid-DONE aborts the transaction; no result is emitted.
- Equality requires all NCHUNK chunks equal; eq is never asserted early.

Optional Feature:
- Macro: SEQ_CMP_EARLY_EXIT_EN.
- Defined: on the first mismatching chunk, COMPARE loads out and moves to DONE on that same edge. Latency is k cycles, where k is the 1-based position of the mismatching chunk from the MSB. Equal operands still take NCHUNK cycles.
- Not defined: fixed NCHUNK-cycle latency as above.
- Result values are identical in both builds.

Test Plan (WIDTH=16, CHUNK=4):
1. Assert rst for 2 cycles, with and without clock edges -> out=000, out_valid=0, in_ready=1, busy=0 immediately.
2. Unsigned, a=0x1234, b=0x1234, out_ready=1 -> out_valid after 4 cycles, out=010, in_ready back to 1 one cycle after handshake.
3. a=0x8000, b=0x7FFF: signed_mode=0 -> out=100; signed_mode=1 -> out=001. Signed a=0xFFFF (-1), b=0x0001 -> out=001.
4. a=0x2000, b=0x1FFF, unsigned -> out=100. Without SEQ_CMP_EARLY_EXIT_EN: 4 cycles. With it: 1 cycle. a=0x1235, b=0x1234 takes 4 cycles in both builds.
5. Hold out_ready=0 for 5 cycles after out_valid, pulse in_valid with new operands -> out_valid and out held, in_ready=0, new operands not captured. Release out_ready -> next transaction accepted one cycle later with correct result.
6. Start a=0x0001, b=0x0002; assert rst on the 2nd COMPARE cycle -> outputs cleared at once, no out_valid. Next transaction a=0x0003, b=0x0003 -> out=010.

Source files
------------

// File: rtl/seq_mag_comparator.sv
// Multi-cycle magnitude comparator: walks WIDTH-bit operands CHUNK bits per cycle, MSB chunk first.
// Optional build macro SEQ_CMP_EARLY_EXIT_EN finishes on the first mismatching chunk.
module seq_mag_comparator #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             signed_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2:0]       out,
    output logic             busy
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0] IDX_TOP = IDXW'(NCHUNK - 1);

`ifdef SEQ_CMP_EARLY_EXIT_EN
    localparam bit EARLY_EXIT = 1'b1;
`else
    localparam bit EARLY_EXIT = 1'b0;
`endif

    localparam logic [2:0] RES_GT = 3'b100;
    localparam logic [2:0] RES_EQ = 3'b010;
    localparam logic [2:0] RES_LT = 3'b001;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPARE = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             sgn_q, sgn_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic             decided_q, decided_d;
    logic [2:0]       res_q, res_d;
    logic [2:0]       out_q, out_d;

    logic [CHUNK-1:0] a_chunk [NCHUNK];
    logic [CHUNK-1:0] b_chunk [NCHUNK];

    genvar gi;
    generate
        for (gi = 0; gi < NCHUNK; gi++) begin : g_chunk
            assign a_chunk[gi] = a_q[gi*CHUNK +: CHUNK];
            assign b_chunk[gi] = b_q[gi*CHUNK +: CHUNK];
        end
    endgenerate

    // Inverting the sign bit of the top chunk maps two's complement onto unsigned order.
    logic [CHUNK-1:0] msb_flip;
    logic [CHUNK-1:0] ca, cb;
    logic             differ;
    logic [2:0]       cmp_res;
    logic             final_cmp;

    always_comb begin
        msb_flip            = '0;
        msb_flip[CHUNK-1]   = sgn_q && (idx_q == IDX_TOP);
        ca                  = a_chunk[idx_q] ^ msb_flip;
        cb                  = b_chunk[idx_q] ^ msb_flip;
        differ              = (ca != cb);
        cmp_res             = (ca > cb) ? RES_GT : RES_LT;
        final_cmp           = (idx_q == '0) || (EARLY_EXIT && !decided_q && differ);
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        sgn_d     = sgn_q;
        idx_d     = idx_q;
        decided_d = decided_q;
        res_d     = res_q;
        out_d     = out_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d       = a;
                    b_d       = b;
                    sgn_d     = signed_mode;
                    idx_d     = IDX_TOP;
                    decided_d = 1'b0;
                    res_d     = 3'b000;
                    state_d   = COMPARE;
                end
            end
            COMPARE: begin
                if (!decided_q && differ) begin
                    decided_d = 1'b1;
                    res_d     = cmp_res;
                end
                if (final_cmp) begin
                    // The deciding chunk may be the one being examined this very cycle.
                    if (decided_q)
                        out_d = res_q;
                    else if (differ)
                        out_d = cmp_res;
                    else
                        out_d = RES_EQ;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q - IDXW'(1);
                end
            end
            DONE: begin
                if (out_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            sgn_q     <= 1'b0;
            idx_q     <= '0;
            decided_q <= 1'b0;
            res_q     <= 3'b000;
            out_q     <= 3'b000;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            sgn_q     <= sgn_d;
            idx_q     <= idx_d;
            decided_q <= decided_d;
            res_q     <= res_d;
            out_q     <= out_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = (state_q == DONE);
    assign out       = out_q;

endmodule

// File: tb/tb_seq_mag_comparator.sv
// Scoreboard bench for seq_mag_comparator (WIDTH=16, CHUNK=4); honours SEQ_CMP_EARLY_EXIT_EN if defined.
module tb_seq_mag_comparator;
    localparam int WIDTH  = 16;
    localparam int CHUNK  = 4;
    localparam int NCHUNK = WIDTH / CHUNK;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             signed_mode = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [2:0]       out;
    logic             busy;

    int checks = 0;
    int errors = 0;

    logic [2:0] exp_q [$];
    int         lat_q [$];

    always #5 clk = ~clk;

    seq_mag_comparator #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .signed_mode(signed_mode),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out        (out),
        .busy       (busy)
    );

    function automatic logic [2:0] model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic s);
        logic gt, lt;
        if (s) begin
            gt = $signed(x) > $signed(y);
            lt = $signed(x) < $signed(y);
        end else begin
            gt = x > y;
            lt = x < y;
        end
        return {gt, !gt && !lt, lt};
    endfunction

    function automatic int exp_lat(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
`ifdef SEQ_CMP_EARLY_EXIT_EN
        for (int k = NCHUNK - 1; k >= 0; k--)
            if (x[k*CHUNK +: CHUNK] != y[k*CHUNK +: CHUNK])
                return NCHUNK - k;
`endif
        return NCHUNK;
    endfunction

    // Called at a falling edge; returns at the falling edge just after the accepting rising edge.
    task automatic start_txn(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic s);
        int n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL start_ready: in_ready=%b required 1", in_ready);
        end
        a = x; b = y; signed_mode = s; in_valid = 1'b1;
        exp_q.push_back(model(x, y, s));
        lat_q.push_back(exp_lat(x, y));
        @(negedge clk);
        in_valid    = 1'b0;
        a           = 16'($urandom);
        b           = 16'($urandom);
        signed_mode = 1'($urandom);
    endtask

    // Waits (bounded) for the result, checks it against the scoreboard, and the handshake if out_ready.
    task automatic collect(input string name);
        int edges = 0;
        logic [2:0] e;
        int l;
        while (!out_valid && edges < 50) begin
            @(negedge clk);
            edges++;
        end
        e = exp_q.pop_front();
        l = lat_q.pop_front();
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s_timeout: out_valid=%b required 1", name, out_valid);
        end
        checks++;
        if (edges !== l) begin
            errors++;
            $display("FAIL %s_latency: got %0d cycles required %0d", name, edges, l);
        end
        checks++;
        if (out !== e) begin
            errors++;
            $display("FAIL %s_result: out=%b required %b", name, out, e);
        end
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s_done_flags: busy=%b in_ready=%b required 1 0", name, busy, in_ready);
        end
        $display("txn %s: out=%b expected=%b latency=%0d", name, out, e, edges);
        if (out_ready) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || out !== e) begin
                errors++;
                $display("FAIL %s_release: out_valid=%b in_ready=%b busy=%b out=%b required 0 1 0 %b",
                         name, out_valid, in_ready, busy, out, e);
            end
        end
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #1;
        checks++;
        if (out !== 3'b000 || out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: out=%b ov=%b ir=%b busy=%b required 000 0 1 0", out, out_valid, in_ready, busy);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (out !== 3'b000 || out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_clocked: out=%b ov=%b ir=%b busy=%b required 000 0 1 0", out, out_valid, in_ready, busy);
        end
        rst = 1'b0;
        @(negedge clk);
        $display("txn reset: out=%b out_valid=%b in_ready=%b busy=%b", out, out_valid, in_ready, busy);
    endtask

    task automatic test_equal();
        start_txn(16'h1234, 16'h1234, 1'b0);
        collect("equal");
    endtask

    task automatic test_signed();
        start_txn(16'h8000, 16'h7FFF, 1'b0);
        collect("unsigned_8000");
        start_txn(16'h8000, 16'h7FFF, 1'b1);
        collect("signed_8000");
        start_txn(16'hFFFF, 16'h0001, 1'b1);
        collect("signed_m1");
    endtask

    task automatic test_latency();
        start_txn(16'h2000, 16'h1FFF, 1'b0);
        collect("top_chunk_diff");
        start_txn(16'h1235, 16'h1234, 1'b0);
        collect("low_chunk_diff");
        start_txn(16'h1244, 16'h1234, 1'b1);
        collect("mid_chunk_diff");
    endtask

    task automatic test_backpressure();
        logic [2:0] held;
        out_ready = 1'b0;
        start_txn(16'h00FF, 16'h0F00, 1'b0);
        collect("bp_first");
        held = out;
        for (int i = 0; i < 5; i++) begin
            a = 16'hFFFF; b = 16'h0000; signed_mode = 1'b0; in_valid = 1'b1;
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out !== held || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold: ov=%b out=%b ir=%b required 1 %b 0", out_valid, out, in_ready, held);
            end
        end
        out_ready = 1'b1;
        exp_q.push_back(model(16'hFFFF, 16'h0000, 1'b0));
        lat_q.push_back(exp_lat(16'hFFFF, 16'h0000));
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: ov=%b ir=%b required 0 1", out_valid, in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        a = 16'($urandom);
        b = 16'($urandom);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL bp_accept: busy=%b required 1", busy);
        end
        collect("bp_second");
    endtask

    task automatic test_reset_abort();
        start_txn(16'h0001, 16'h0002, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        void'(exp_q.pop_back());
        void'(lat_q.pop_back());
        checks++;
        if (out !== 3'b000 || out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_reset: out=%b ov=%b ir=%b busy=%b required 000 0 1 0", out, out_valid, in_ready, busy);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL abort_no_result: out_valid=%b required 0", out_valid);
            end
        end
        $display("txn abort: no result emitted");
        start_txn(16'h0003, 16'h0003, 1'b0);
        collect("after_abort");
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] x, y;
        logic s;
        start_txn(16'h0000, 16'hFFFF, 1'b1);
        collect("b2b_zero_vs_m1");
        start_txn(16'h7FFF, 16'h8000, 1'b1);
        collect("b2b_max_vs_min");
        for (int i = 0; i < 8; i++) begin
            x = 16'($urandom);
            y = (i % 3 == 0) ? x : 16'($urandom);
            s = 1'($urandom);
            start_txn(x, y, s);
            collect("b2b_random");
        end
    endtask

    initial begin
        test_reset();
        test_equal();
        test_signed();
        test_latency();
        test_backpressure();
        test_reset_abort();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
